// File: rtl/lsu_mem_pkg.sv
// Shared types and defaults for the LSU-facing memory responder.
package lsu_mem_pkg;

  localparam int DEPTH_DEFAULT   = 256;
  localparam int LATENCY_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Misaligned, out-of-range and empty-lane requests are all rejected.
  function automatic logic req_error(input logic [1:0]  addr_lo,
                                     input logic [31:0] word_idx,
                                     input logic [3:0]  be,
                                     input int unsigned depth);
    return (addr_lo != 2'b00) || (word_idx >= depth) || (be == 4'h0);
  endfunction

endpackage

// File: rtl/lsu_mem_array.sv
// Word-addressed storage built from four byte-lane arrays: synchronous
// byte-enabled write, combinational read.
module lsu_mem_array #(
  parameter int DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     i_we,
  input  logic [3:0]               i_be,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] r_lane [DEPTH];

    always_ff @(posedge clk_i) begin
      if (i_we && i_be[gi]) begin
        r_lane[i_addr] <= i_wdata[gi*8 +: 8];
      end
    end

    assign o_rdata[gi*8 +: 8] = r_lane[i_addr];
  end

endmodule

// File: rtl/lsu_mem_resp.sv
// Single-outstanding LSU data-port responder with fixed response latency.
// The captured request is decoded in RESP, where the write commits and rdata is returned.
module lsu_mem_resp
  import lsu_mem_pkg::*;
#(
  parameter int          DEPTH     = DEPTH_DEFAULT,
  parameter int          LATENCY   = LATENCY_DEFAULT,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int AW = $clog2(DEPTH);

  state_e      r_state;
  state_e      w_state_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic [31:0] w_word_idx;
  logic        w_err;
  logic        w_mem_we;
  logic [31:0] w_mem_rdata;

  assign w_word_idx = (r_addr - BASE_ADDR) >> 2;
  assign w_err      = req_error(r_addr[1:0], w_word_idx, r_be, DEPTH);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_be    <= 4'h0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (data_gnt_o) begin
            r_we    <= data_we_i;
            r_be    <= data_be_i;
            r_addr  <= data_addr_i;
            r_wdata <= data_wdata_i;
            r_cnt   <= 4'(LATENCY - 1);
          end
        end
        WAIT:    r_cnt <= r_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (data_gnt_o) begin
          w_state_next = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Gating on rst_ni keeps a reset landing in RESP from leaking a response or a write.
  always_comb begin
    data_gnt_o    = 1'b0;
    data_rvalid_o = 1'b0;
    data_err_o    = 1'b0;
    data_rdata_o  = 32'h0;
    w_mem_we      = 1'b0;
    if (rst_ni) begin
      case (r_state)
        IDLE: data_gnt_o = data_req_i;
        RESP: begin
          data_rvalid_o = 1'b1;
          data_err_o    = w_err;
          data_rdata_o  = (w_err || r_we) ? 32'h0 : w_mem_rdata;
          w_mem_we      = r_we && !w_err;
        end
        default: ;
      endcase
    end
  end

  lsu_mem_array #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk_i  (clk_i),
    .i_we   (w_mem_we),
    .i_be   (r_be),
    .i_addr (w_word_idx[AW-1:0]),
    .i_wdata(r_wdata),
    .o_rdata(w_mem_rdata)
  );

endmodule

// File: tb/tb_lsu_mem_resp.sv
// Directed bench for lsu_mem_resp: one LATENCY=2 instance carries the memory
// scenarios, LATENCY=1 and LATENCY=4 instances check grant/response spacing.
module tb_lsu_mem_resp;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic        req, req1, req4;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        gnt, rvalid, err;
  logic [31:0] rdata;
  logic        gnt1, rvalid1, err1;
  logic [31:0] rdata1;
  logic        gnt4, rvalid4, err4;
  logic [31:0] rdata4;

  int total = 0;
  int bad   = 0;

  lsu_mem_resp #(.DEPTH(DEPTH), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_we_i(we),
    .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_gnt_o(gnt), .data_rvalid_o(rvalid), .data_rdata_o(rdata),
    .data_err_o(err)
  );

  lsu_mem_resp #(.DEPTH(DEPTH), .LATENCY(1), .BASE_ADDR(32'h0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req1), .data_we_i(we),
    .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_gnt_o(gnt1), .data_rvalid_o(rvalid1), .data_rdata_o(rdata1),
    .data_err_o(err1)
  );

  lsu_mem_resp #(.DEPTH(DEPTH), .LATENCY(4), .BASE_ADDR(32'h0)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req4), .data_we_i(we),
    .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_gnt_o(gnt4), .data_rvalid_o(rvalid4), .data_rdata_o(rdata4),
    .data_err_o(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full LATENCY=2 transaction on dut; starts and ends 1 time unit after a rising edge.
  task automatic txn(input string tag, input logic t_we, input logic [3:0] t_be,
                     input logic [31:0] t_addr, input logic [31:0] t_wd,
                     input logic [31:0] exp_rd, input logic exp_err);
    req = 1'b1; we = t_we; be = t_be; addr = t_addr; wdata = t_wd;
    #1 chk({tag, "_gnt"}, 32'(gnt), 32'd1);
    @(posedge clk); #1;
    // request dropped and inputs scrambled: must not disturb the captured transaction
    req = 1'b0; we = ~t_we; be = ~t_be; addr = ~t_addr; wdata = ~t_wd;
    #1 chk({tag, "_wait_rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, "_wait_gnt"}, 32'(gnt), 32'd0);
    @(posedge clk); #1;
    #1 chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_rdata"}, rdata, exp_rd);
    $display("txn %s we=%0b be=%h addr=%h wdata=%h rdata=%h err=%0b",
             tag, t_we, t_be, t_addr, t_wd, rdata, err);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b1; req1 = 1'b1; req4 = 1'b1;
    we = 1'b0; be = 4'hF; addr = 32'h4; wdata = 32'h0;

    // reset with requests pending
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_gnt1", 32'(gnt1), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdata", rdata, 32'h0);
      $display("txn reset cycle %0d gnt=%0b rvalid=%0b", i, gnt, rvalid);
    end
    rst_n = 1'b1; req = 1'b0; req1 = 1'b0; req4 = 1'b0;
    @(posedge clk); #2;
    chk("post_rst_rvalid", 32'(rvalid), 32'd0);
    chk("post_rst_err", 32'(err), 32'd0);
    chk("post_rst_rdata", rdata, 32'h0);
    @(posedge clk); #1;

    // write then read
    txn("wr4", 1'b1, 4'hF, 32'h4, 32'h0000000F, 32'h0, 1'b0);
    txn("rd4", 1'b0, 4'hF, 32'h4, 32'h0, 32'h0000000F, 1'b0);

    // partial write into a single lane
    txn("wr8", 1'b1, 4'hF, 32'h8, 32'hAABBCCDD, 32'h0, 1'b0);
    txn("wr8_lane1", 1'b1, 4'b0010, 32'h8, 32'h00001100, 32'h0, 1'b0);
    txn("rd8", 1'b0, 4'hF, 32'h8, 32'h0, 32'hAABB11DD, 1'b0);
    txn("rd8_be1", 1'b0, 4'b0001, 32'h8, 32'h0, 32'hAABB11DD, 1'b0);

    // error cases leave memory untouched
    txn("wr0", 1'b1, 4'hF, 32'h0, 32'h11111111, 32'h0, 1'b0);
    txn("wr_misal", 1'b1, 4'hF, 32'h5, 32'h12345678, 32'h0, 1'b1);
    txn("rd4_after_misal", 1'b0, 4'hF, 32'h4, 32'h0, 32'h0000000F, 1'b0);
    txn("rd_misal", 1'b0, 4'hF, 32'h5, 32'h0, 32'h0, 1'b1);
    txn("wr_oob", 1'b1, 4'hF, 32'(DEPTH * 4), 32'hDEADBEEF, 32'h0, 1'b1);
    txn("rd0_after_oob", 1'b0, 4'hF, 32'h0, 32'h0, 32'h11111111, 1'b0);
    txn("rd_oob", 1'b0, 4'hF, 32'(DEPTH * 4), 32'h0, 32'h0, 1'b1);
    txn("wr_be0", 1'b1, 4'h0, 32'h8, 32'hFFFFFFFF, 32'h0, 1'b1);
    txn("rd8_after_be0", 1'b0, 4'hF, 32'h8, 32'h0, 32'hAABB11DD, 1'b0);
    txn("rd_be0", 1'b0, 4'h0, 32'h8, 32'h0, 32'h0, 1'b1);

    // back-to-back: LATENCY=2 grants every 3 cycles, LATENCY=1 alternates
    req = 1'b1; req1 = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h4;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("b2b_gnt", 32'(gnt), 32'(i % 3 == 0));
      chk("b2b_rvalid", 32'(rvalid), 32'(i % 3 == 2));
      chk("b2b_gnt1", 32'(gnt1), 32'(i % 2 == 0));
      chk("b2b_rvalid1", 32'(rvalid1), 32'(i % 2 == 1));
      if (i % 3 == 2) chk("b2b_rdata", rdata, 32'h0000000F);
      $display("txn b2b cycle %0d gnt=%0b rvalid=%0b gnt1=%0b rvalid1=%0b",
               i, gnt, rvalid, gnt1, rvalid1);
      @(posedge clk); #1;
    end
    req = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;

    // LATENCY=4 spacing with request held high
    req4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("l4_gnt", 32'(gnt4), 32'(i == 0 || i == 5));
      chk("l4_rvalid", 32'(rvalid4), 32'(i == 4));
      $display("txn lat4 cycle %0d gnt=%0b rvalid=%0b", i, gnt4, rvalid4);
      @(posedge clk); #1;
    end
    req4 = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // reset in WAIT aborts a write
    txn("wr10", 1'b1, 4'hF, 32'h10, 32'h55AA55AA, 32'h0, 1'b0);
    req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h10; wdata = 32'hFFFFFFFF;
    #1 chk("abort_gnt", 32'(gnt), 32'd1);
    @(posedge clk); #1;
    req = 1'b0; rst_n = 1'b0;
    #1 chk("abort_rvalid_rst", 32'(rvalid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("abort_rvalid_c2", 32'(rvalid), 32'd0);
    @(posedge clk); #1;
    #1 chk("abort_rvalid_c3", 32'(rvalid), 32'd0);
    $display("txn abort write addr=00000010 rvalid=%0b", rvalid);
    @(posedge clk); #1;
    txn("rd10_after_abort", 1'b0, 4'hF, 32'h10, 32'h0, 32'h55AA55AA, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
